// File: rtl/int_priority_ctrl_if.sv
// int_priority_ctrl_if: request/acknowledge handshake between interrupt controller and CPU
interface int_priority_ctrl_if;
  logic irq_req;
  logic [1:0] irq_id;
  logic [31:0] irq_vector;
  logic irq_ack;
  logic irq_eret;
  modport master (output irq_req, irq_id, irq_vector, input irq_ack, irq_eret);
  modport slave (input irq_req, irq_id, irq_vector, output irq_ack, irq_eret);
endinterface

// File: rtl/int_priority_ctrl.sv
// int_priority_ctrl: three-level nested-priority interrupt controller with edge capture and eret sequencing
module int_priority_ctrl #(
  parameter logic [31:0] VEC_BASE = 32'h0000_0800,
  parameter logic [31:0] VEC_STRIDE = 32'h0000_0080
) (
  input logic clk,
  input logic clr,
  input logic inter1,
  input logic inter2,
  input logic inter3,
  input logic [2:0] mask,
  int_priority_ctrl_if.master bus,
  output logic [1:0] cur_level,
  output logic inter_running1,
  output logic inter_running2,
  output logic inter_running3
);
  localparam logic IDLE = 1'b0;
  localparam logic REQ = 1'b1;
  logic state;
  logic [1:0] id, best;
  logic [3:1] src, src_d, rise, pending, isr, elig, id_oh, top_oh;
  logic ack_fire, eret_fire;
  assign src = {inter3, inter2, inter1};
  assign rise = src & ~src_d;
  always_comb begin
    cur_level = isr[3] ? 2'd3 : isr[2] ? 2'd2 : isr[1] ? 2'd1 : 2'd0;
    top_oh = isr[3] ? 3'b100 : isr[2] ? 3'b010 : isr[1] ? 3'b001 : 3'b000;
    elig = pending & mask & {cur_level < 2'd3, cur_level < 2'd2, cur_level == 2'd0};
    best = elig[3] ? 2'd3 : elig[2] ? 2'd2 : elig[1] ? 2'd1 : 2'd0;
    id_oh = {id == 2'd3, id == 2'd2, id == 2'd1};
    ack_fire = state == REQ && bus.irq_ack;
    eret_fire = bus.irq_eret && !ack_fire;
  end
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      src_d <= '0;
      pending <= '0;
      isr <= '0;
      state <= IDLE;
      id <= '0;
    end else begin
      src_d <= src;
      pending <= (pending & ~(ack_fire ? id_oh : 3'b000)) | rise;
      isr <= ack_fire ? isr | id_oh : eret_fire ? isr & ~top_oh : isr;
      state <= (!ack_fire && best != 2'd0) ? REQ : IDLE;
      id <= ack_fire ? 2'd0 : best;
    end
  end
  assign bus.irq_req = state;
  assign bus.irq_id = id;
  assign bus.irq_vector = state ? VEC_BASE + ({30'd0, id} - 32'd1) * VEC_STRIDE : 32'd0;
  assign {inter_running3, inter_running2, inter_running1} = isr;
endmodule

// File: tb/tb_int_priority_ctrl.sv
// tb_int_priority_ctrl: directed plan scenarios plus random traffic against a behavioural model
module tb_int_priority_ctrl;
  localparam logic [31:0] VB = 32'h0000_0800;
  localparam logic [31:0] VS = 32'h0000_0080;
  logic clk = 1'b0;
  logic clr;
  logic inter1, inter2, inter3;
  logic [2:0] mask;
  logic [1:0] cur_level;
  logic inter_running1, inter_running2, inter_running3;
  int errors = 0;
  int checks = 0;
  int m_pend [1:3];
  int m_isr [1:3];
  int m_prev [1:3];
  bit m_req;
  int m_id;

  int_priority_ctrl_if bus ();

  int_priority_ctrl #(.VEC_BASE(VB), .VEC_STRIDE(VS)) dut (
    .clk(clk), .clr(clr), .inter1(inter1), .inter2(inter2), .inter3(inter3),
    .mask(mask), .bus(bus), .cur_level(cur_level),
    .inter_running1(inter_running1), .inter_running2(inter_running2), .inter_running3(inter_running3)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  function automatic int m_cur();
    int c = 0;
    for (int i = 1; i <= 3; i++) if (m_isr[i] != 0) c = i;
    return c;
  endfunction

  task automatic model_reset();
    for (int i = 1; i <= 3; i++) begin
      m_pend[i] = 0;
      m_isr[i] = 0;
      m_prev[i] = 0;
    end
    m_req = 0;
    m_id = 0;
  endtask

  task automatic model_step();
    int src [1:3];
    int cl, best;
    bit ackd;
    src[1] = int'(inter1);
    src[2] = int'(inter2);
    src[3] = int'(inter3);
    cl = m_cur();
    best = 0;
    for (int i = 1; i <= 3; i++) if (m_pend[i] != 0 && mask[i-1] && i > cl) best = i;
    ackd = m_req && bus.irq_ack;
    if (ackd) m_pend[m_id] = 0;
    for (int i = 1; i <= 3; i++) begin
      if (src[i] != 0 && m_prev[i] == 0) m_pend[i] = 1;
      m_prev[i] = src[i];
    end
    if (ackd) m_isr[m_id] = 1;
    else if (bus.irq_eret && cl > 0) m_isr[cl] = 0;
    m_req = !ackd && best > 0;
    m_id = ackd ? 0 : best;
  endtask

  task automatic check_all();
    chk("irq_req", 32'(bus.irq_req), 32'(m_req));
    chk("irq_id", 32'(bus.irq_id), 32'(m_id));
    chk("irq_vector", bus.irq_vector, m_req ? VB + 32'(m_id - 1) * VS : 32'd0);
    chk("cur_level", 32'(cur_level), 32'(m_cur()));
    chk("running", 32'({inter_running3, inter_running2, inter_running1}),
        32'({m_isr[3] != 0, m_isr[2] != 0, m_isr[1] != 0}));
  endtask

  task automatic tick();
    @(posedge clk);
    if (clr) model_step();
    else model_reset();
    #1;
    check_all();
  endtask

  task automatic set_src(input logic [2:0] s);
    {inter3, inter2, inter1} = s;
  endtask

  task automatic pulse(input logic [2:0] s);
    set_src(s);
    tick();
    set_src(3'b000);
  endtask

  task automatic ack_once();
    bus.irq_ack = 1'b1;
    tick();
    bus.irq_ack = 1'b0;
  endtask

  task automatic eret_once();
    bus.irq_eret = 1'b1;
    tick();
    bus.irq_eret = 1'b0;
  endtask

  initial begin
    clr = 1'b0;
    set_src(3'b000);
    mask = 3'b111;
    bus.irq_ack = 1'b0;
    bus.irq_eret = 1'b0;
    model_reset();
    #2;
    check_all();
    chk("reset_outs", 32'({bus.irq_req, bus.irq_id, cur_level, inter_running3, inter_running2, inter_running1}), 32'd0);
    tick();
    clr = 1'b1;
    pulse(3'b001);
    tick();
    chk("t1_id", 32'(bus.irq_id), 32'd1);
    chk("t1_vec", bus.irq_vector, 32'h800);
    ack_once();
    chk("t1_run1", 32'(inter_running1), 32'd1);
    chk("t1_cur", 32'(cur_level), 32'd1);
    eret_once();
    chk("t1_clear", 32'({bus.irq_req, cur_level, inter_running3, inter_running2, inter_running1}), 32'd0);
    pulse(3'b001);
    tick();
    ack_once();
    pulse(3'b100);
    tick();
    chk("t2_id", 32'(bus.irq_id), 32'd3);
    chk("t2_vec", bus.irq_vector, 32'h900);
    ack_once();
    chk("t2_run", 32'({inter_running3, inter_running2, inter_running1}), 32'b101);
    chk("t2_cur", 32'(cur_level), 32'd3);
    eret_once();
    chk("t2_eret1", 32'({inter_running3, inter_running2, inter_running1}), 32'b001);
    eret_once();
    chk("t2_eret2", 32'({inter_running3, inter_running2, inter_running1}), 32'b000);
    pulse(3'b100);
    tick();
    ack_once();
    pulse(3'b001);
    tick();
    tick();
    chk("t3_blocked", 32'(bus.irq_req), 32'd0);
    eret_once();
    chk("t3_after_e", 32'(bus.irq_req), 32'd0);
    tick();
    chk("t3_req", 32'({bus.irq_req, bus.irq_id}), 32'b101);
    ack_once();
    eret_once();
    pulse(3'b110);
    tick();
    chk("t4_first", 32'(bus.irq_id), 32'd3);
    ack_once();
    tick();
    chk("t4_hold", 32'(bus.irq_req), 32'd0);
    eret_once();
    tick();
    chk("t4_second", 32'(bus.irq_id), 32'd2);
    ack_once();
    eret_once();
    mask = 3'b101;
    pulse(3'b010);
    tick();
    tick();
    tick();
    chk("t5_masked", 32'(bus.irq_req), 32'd0);
    mask = 3'b111;
    tick();
    chk("t5_enabled", 32'(bus.irq_id), 32'd2);
    mask = 3'b101;
    tick();
    chk("t5_withdraw", 32'(bus.irq_req), 32'd0);
    mask = 3'b111;
    tick();
    chk("t5_kept", 32'({bus.irq_req, bus.irq_id}), 32'b110);
    ack_once();
    eret_once();
    pulse(3'b001);
    tick();
    ack_once();
    pulse(3'b100);
    tick();
    ack_once();
    pulse(3'b010);
    tick();
    chk("t6_pre", 32'({inter_running3, inter_running2, inter_running1}), 32'b101);
    #2;
    clr = 1'b0;
    model_reset();
    #1;
    check_all();
    chk("t6_async", 32'({bus.irq_req, bus.irq_id, cur_level, inter_running3, inter_running2, inter_running1}), 32'd0);
    tick();
    clr = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    chk("t6_quiet", 32'(bus.irq_req), 32'd0);
    for (int i = 0; i < 3000; i++) begin
      set_src({$urandom_range(3) == 0, $urandom_range(3) == 0, $urandom_range(3) == 0});
      if ($urandom_range(7) == 0) mask = 3'($urandom);
      bus.irq_ack = $urandom_range(1) == 1;
      bus.irq_eret = $urandom_range(4) == 0;
      tick();
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
